// File: rtl/motion_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : motion_encoder_if
//  Brief    : Key-state input and registered motion-word output bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface motion_encoder_if;
    logic        enable;
    logic [31:0] keys;
    logic [15:0] keycode;
    logic        select_pulse;
    logic        moving;

    modport master (output enable, keys, input keycode, select_pulse, moving);
    modport slave  (input enable, keys, output keycode, select_pulse, moving);
endinterface
`default_nettype wire

// File: rtl/motion_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : motion_encoder
//  Brief    : HID key slots to per-frame X/Y step with hold-then-ramp speed.
//  Revision : 1.0  initial release
// ============================================================================
module motion_encoder #(
    parameter int START_SPEED = 1,
    parameter int HOLD_FRAMES = 8,
    parameter int RAMP_PERIOD = 4,
    parameter int MAX_SPEED   = 8
) (
    input  logic             frame_clk,
    input  logic             Reset,
    motion_encoder_if.slave  bus
);

    localparam int c_CNT_MAX = (HOLD_FRAMES > RAMP_PERIOD) ? HOLD_FRAMES : RAMP_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD  = c_CNT_W'(HOLD_FRAMES);
    localparam logic [c_CNT_W-1:0] c_RAMP  = c_CNT_W'(RAMP_PERIOD);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [6:0]         c_START = 7'(START_SPEED);
    localparam logic [6:0]         c_MAX   = 7'(MAX_SPEED);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RAMP = 2'd2
    } axis_state_t;

    function automatic logic key_held(input logic [31:0] k, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (k[8*i +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    logic        w_enable;
    logic [31:0] w_keys;
    logic [1:0]  w_dir_pos;
    logic [1:0]  w_dir_neg;
    logic        w_sel;
    logic [15:0] w_keycode_nxt;

    logic [15:0] r_keycode;
    logic        r_moving;
    logic        r_select;
    logic        r_sel_prev;

    assign w_enable = bus.enable;
    assign w_keys   = bus.keys;

    // Index 0 is the X axis (Right positive), index 1 the Y axis (Down positive).
    always_comb begin
        w_dir_pos[0] = key_held(w_keys, 8'h07) | key_held(w_keys, 8'h4F);
        w_dir_neg[0] = key_held(w_keys, 8'h04) | key_held(w_keys, 8'h50);
        w_dir_pos[1] = key_held(w_keys, 8'h16) | key_held(w_keys, 8'h51);
        w_dir_neg[1] = key_held(w_keys, 8'h1A) | key_held(w_keys, 8'h52);
        w_sel        = key_held(w_keys, 8'h2C) | key_held(w_keys, 8'h28);
    end

    generate
        for (genvar a = 0; a < 2; a++) begin : g_axis
            axis_state_t         r_state, w_state_nxt;
            logic [6:0]          r_speed, w_speed_nxt, w_speed_inc;
            logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
            logic                r_neg, w_neg_nxt;
            logic                w_active;

            always_ff @(posedge frame_clk or posedge Reset) begin
                if (Reset) begin
                    r_state <= S_IDLE;
                    r_speed <= '0;
                    r_cnt   <= '0;
                    r_neg   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_speed <= w_speed_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_neg   <= w_neg_nxt;
                end
            end

            always_comb begin
                w_active    = w_dir_pos[a] ^ w_dir_neg[a];
                w_speed_inc = (r_speed >= c_MAX) ? c_MAX : r_speed + 7'd1;
                w_state_nxt = S_IDLE;
                w_speed_nxt = '0;
                w_cnt_nxt   = '0;
                w_neg_nxt   = 1'b0;
                if (w_enable && w_active) begin
                    w_neg_nxt = w_dir_neg[a];
                    // A fresh press or a reversal both restart the hold window.
                    if (r_state == S_IDLE || w_dir_neg[a] != r_neg) begin
                        w_state_nxt = S_HOLD;
                        w_speed_nxt = c_START;
                        w_cnt_nxt   = c_ONE;
                    end else if (r_state == S_HOLD) begin
                        if (r_cnt == c_HOLD) begin
                            w_state_nxt = S_RAMP;
                            w_speed_nxt = w_speed_inc;
                            w_cnt_nxt   = c_ONE;
                        end else begin
                            w_state_nxt = S_HOLD;
                            w_speed_nxt = r_speed;
                            w_cnt_nxt   = r_cnt + c_ONE;
                        end
                    end else begin
                        w_state_nxt = S_RAMP;
                        if (r_cnt == c_RAMP) begin
                            w_speed_nxt = w_speed_inc;
                            w_cnt_nxt   = c_ONE;
                        end else begin
                            w_speed_nxt = r_speed;
                            w_cnt_nxt   = r_cnt + c_ONE;
                        end
                    end
                end
            end

            assign w_keycode_nxt[8*a +: 8] = (w_state_nxt == S_IDLE) ? 8'h00 :
                                             w_neg_nxt ? 8'(~{1'b0, w_speed_nxt} + 8'd1) :
                                                         {1'b0, w_speed_nxt};
        end
    endgenerate

    // Select history keeps tracking while disabled so a held key never pulses on enable.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_keycode  <= '0;
            r_moving   <= 1'b0;
            r_select   <= 1'b0;
            r_sel_prev <= 1'b0;
        end else begin
            r_keycode  <= w_keycode_nxt;
            r_moving   <= |w_keycode_nxt;
            r_select   <= w_enable & w_sel & ~r_sel_prev;
            r_sel_prev <= w_sel;
        end
    end

    assign bus.keycode      = r_keycode;
    assign bus.moving       = r_moving;
    assign bus.select_pulse = r_select;

endmodule
`default_nettype wire

// File: tb/tb_motion_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motion_encoder
//  Brief    : Directed and random key stimulus against a run-length speed model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_motion_encoder;

    localparam int START_SPEED = 1;
    localparam int HOLD_FRAMES = 8;
    localparam int RAMP_PERIOD = 4;
    localparam int MAX_SPEED   = 8;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    motion_encoder_if bus ();

    motion_encoder #(
        .START_SPEED (START_SPEED),
        .HOLD_FRAMES (HOLD_FRAMES),
        .RAMP_PERIOD (RAMP_PERIOD),
        .MAX_SPEED   (MAX_SPEED)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each axis remembers how many frames the current direction has run.
    int          run [2];
    int          sgn [2];
    bit          prev_sel;
    logic [15:0] exp_kc;
    logic        exp_mv;
    logic        exp_sp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit held(input logic [31:0] k, input logic [7:0] c);
        for (int i = 0; i < 4; i++) if (k[8*i +: 8] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int speed_of(input int n);
        int s;
        if (n <= HOLD_FRAMES) return START_SPEED;
        s = START_SPEED + 1 + (n - HOLD_FRAMES - 1) / RAMP_PERIOD;
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

    task automatic model_reset();
        run[0] = 0; run[1] = 0; sgn[0] = 0; sgn[1] = 0;
        prev_sel = 1'b0;
        exp_kc = '0; exp_mv = 1'b0; exp_sp = 1'b0;
    endtask

    task automatic model_step();
        int d [2];
        bit sel;
        logic [31:0] k;
        k = bus.keys;
        d[0] = int'(held(k, 8'h07) || held(k, 8'h4F)) - int'(held(k, 8'h04) || held(k, 8'h50));
        d[1] = int'(held(k, 8'h16) || held(k, 8'h51)) - int'(held(k, 8'h1A) || held(k, 8'h52));
        for (int a = 0; a < 2; a++) begin
            if (!bus.enable || d[a] == 0) run[a] = 0;
            else if (run[a] == 0 || d[a] != sgn[a]) begin run[a] = 1; sgn[a] = d[a]; end
            else run[a]++;
            exp_kc[8*a +: 8] = (run[a] == 0) ? 8'h00 : 8'(sgn[a] * speed_of(run[a]));
        end
        exp_mv = (exp_kc != 16'h0000);
        sel = held(k, 8'h2C) || held(k, 8'h28);
        exp_sp = bus.enable && sel && !prev_sel;
        prev_sel = sel;
    endtask

    // One frame: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge frame_clk);
        if (Reset) model_reset();
        else model_step();
        #1;
        chk("keycode", 32'(bus.keycode), 32'(exp_kc));
        chk("moving", 32'(bus.moving), 32'(exp_mv));
        chk("select_pulse", 32'(bus.select_pulse), 32'(exp_sp));
    endtask

    task automatic drive(input logic [31:0] k, input logic en);
        bus.keys = k;
        bus.enable = en;
    endtask

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 19))
            0: return 8'h04;  1: return 8'h07;  2: return 8'h1A;  3: return 8'h16;
            4: return 8'h50;  5: return 8'h4F;  6: return 8'h52;  7: return 8'h51;
            8: return 8'h2C;  9: return 8'h28; 10: return 8'h05; 11: return 8'hFF;
            12: return 8'h29; default: return 8'h00;
        endcase
    endfunction

    task automatic async_reset_check();
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_keycode", 32'(bus.keycode), 32'h0);
        chk("async_rst_moving", 32'(bus.moving), 32'h0);
        model_reset();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        model_reset();
        drive(32'h0000_0007, 1'b1);
        #1;
        chk("rst_keycode", 32'(bus.keycode), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_select", 32'(bus.select_pulse), 32'h0);
        Reset = 1'b0;

        // D held from frame 1: hold then ramp to ceiling
        for (int f = 1; f <= 40; f++) begin
            tick();
            if (f == 1 || f == 8) chk("ramp_hold", 32'(bus.keycode), 32'h0001);
            if (f == 9 || f == 12) chk("ramp_2", 32'(bus.keycode), 32'h0002);
            if (f == 13) chk("ramp_3", 32'(bus.keycode), 32'h0003);
            if (f == 33 || f == 40) chk("ramp_max", 32'(bus.keycode), 32'h0008);
        end

        drive(32'h0, 1'b1); tick();
        drive(32'h0000_5000, 1'b1); tick();
        chk("left_arrow", 32'(bus.keycode), 32'h00FF);
        drive(32'h0000_1A04, 1'b1); tick();
        chk("up_left", 32'(bus.keycode), 32'hFFFF);
        drive(32'h161A_0000, 1'b1); tick();
        chk("w_plus_s", 32'(bus.keycode), 32'h0000);
        chk("w_plus_s_moving", 32'(bus.moving), 32'h0);

        // Reversal after 20 frames of D
        drive(32'h0, 1'b1); tick();
        drive(32'h0000_0007, 1'b1);
        for (int f = 1; f <= 20; f++) tick();
        chk("pre_reverse", 32'(bus.keycode), 32'h0004);
        drive(32'h0000_0004, 1'b1);
        for (int f = 21; f <= 29; f++) begin
            tick();
            if (f == 21) chk("reverse_start", 32'(bus.keycode), 32'h00FF);
            if (f == 29) chk("reverse_ramp", 32'(bus.keycode), 32'h00FE);
        end

        // Select edges
        drive(32'h0, 1'b1); tick();
        drive(32'h0000_002C, 1'b1);
        for (int f = 1; f <= 5; f++) begin
            tick();
            chk("space_held", 32'(bus.select_pulse), (f == 1) ? 32'h1 : 32'h0);
        end
        drive(32'h0, 1'b1); tick();
        drive(32'h0000_002C, 1'b1); tick();
        chk("space_repress", 32'(bus.select_pulse), 32'h1);
        drive(32'h0, 1'b1); tick();
        drive(32'h0000_282C, 1'b1); tick();
        chk("space_enter", 32'(bus.select_pulse), 32'h1);
        tick();
        chk("space_enter_hold", 32'(bus.select_pulse), 32'h0);
        drive(32'h0, 1'b0); tick();
        drive(32'h0000_002C, 1'b0); tick();
        drive(32'h0000_002C, 1'b1); tick();
        chk("sel_across_enable", 32'(bus.select_pulse), 32'h0);

        // Enable gating and restart
        drive(32'h0000_0007, 1'b1);
        for (int f = 0; f < 5; f++) tick();
        drive(32'h0000_0007, 1'b0); tick();
        chk("disabled", 32'(bus.keycode), 32'h0000);
        drive(32'h0000_0007, 1'b1); tick();
        chk("enable_restart", 32'(bus.keycode), 32'h0001);

        // Reset in the middle of a ramp
        drive(32'h0, 1'b1); tick();
        drive(32'h0000_0007, 1'b1);
        for (int f = 0; f < 25; f++) tick();
        async_reset_check();
        tick();
        chk("post_reset", 32'(bus.keycode), 32'h0001);

        // Randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            logic [31:0] k;
            for (int s = 0; s < 4; s++) k[8*s +: 8] = rand_code();
            drive(k, ($urandom_range(0, 7) != 0));
            for (int f = 0, n = $urandom_range(1, 40); f < n; f++) tick();
            if (seg % 15 == 14) async_reset_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
